// File: rtl/imm_gen_stage.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_stage
// Description : RV32 immediate-generation pipeline stage. Decodes the
//               instruction format from the opcode, builds the sign- or
//               zero-extended immediate and presents it one cycle after
//               acceptance. A two-entry (output + skid) buffer keeps full
//               throughput under downstream backpressure.
// Ports       : clk, rst_n (async active-low), flush (sync discard)
//               in_valid/in_ready/inst_in            - upstream handshake
//               out_valid/out_ready/imm_out/type_out/
//               illegal_out/inst_out                 - downstream entry
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_stage #(
  parameter int INST_WIDTH = 32,
  parameter int IMM_WIDTH  = 32,
  parameter int ENABLE_CSR = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INST_WIDTH-1:0] inst_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IMM_WIDTH-1:0]  imm_out,
  output logic [2:0]            type_out,
  output logic                  illegal_out,
  output logic [INST_WIDTH-1:0] inst_out
);

  // Opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Format codes on type_out
  localparam logic [2:0] TYPE_R   = 3'd0;
  localparam logic [2:0] TYPE_I   = 3'd1;
  localparam logic [2:0] TYPE_U   = 3'd2;
  localparam logic [2:0] TYPE_UJ  = 3'd3;
  localparam logic [2:0] TYPE_SB  = 3'd4;
  localparam logic [2:0] TYPE_S   = 3'd5;
  localparam logic [2:0] TYPE_CSR = 3'd6;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // --------------------------------------------------------------------------
  logic [31:0]          dec_imm32;
  logic [IMM_WIDTH-1:0] dec_imm;
  logic [2:0]           dec_type;
  logic                 dec_illegal;

  always_comb begin
    dec_imm32   = '0;
    dec_type    = TYPE_R;
    dec_illegal = 1'b0;
    case (inst_in[6:0])
      OP_R: begin
        dec_type = TYPE_R;
      end
      OP_IMM, OP_JALR, OP_LOAD, OP_FENCE: begin
        dec_type  = TYPE_I;
        dec_imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
      end
      OP_AUIPC, OP_LUI: begin
        dec_type  = TYPE_U;
        dec_imm32 = {inst_in[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_type  = TYPE_UJ;
        dec_imm32 = {{12{inst_in[31]}}, inst_in[19:12], inst_in[20],
                     inst_in[30:21], 1'b0};
      end
      OP_BRANCH: begin
        dec_type  = TYPE_SB;
        dec_imm32 = {{20{inst_in[31]}}, inst_in[7], inst_in[30:25],
                     inst_in[11:8], 1'b0};
      end
      OP_STORE: begin
        dec_type  = TYPE_S;
        dec_imm32 = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
      end
      OP_SYSTEM: begin
        // funct3[2] selects the immediate (zimm) CSR variants
        if ((ENABLE_CSR != 0) && inst_in[14]) begin
          dec_type  = TYPE_CSR;
          dec_imm32 = {27'b0, inst_in[19:15]};
        end else begin
          dec_type  = TYPE_I;
          dec_imm32 = {{20{inst_in[31]}}, inst_in[31:20]};
        end
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Bit 31 of the 32-bit result already carries the right extension bit
  // (zimm has it cleared), so widening is a plain sign replication.
  generate
    if (IMM_WIDTH > 32) begin : g_imm_ext_wide
      assign dec_imm = {{(IMM_WIDTH-32){dec_imm32[31]}}, dec_imm32};
    end else begin : g_imm_ext_exact
      assign dec_imm = dec_imm32;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output register + skid register
  // --------------------------------------------------------------------------
  logic                  out_valid_q,   out_valid_d;
  logic [IMM_WIDTH-1:0]  out_imm_q,     out_imm_d;
  logic [2:0]            out_type_q,    out_type_d;
  logic                  out_illegal_q, out_illegal_d;
  logic [INST_WIDTH-1:0] out_inst_q,    out_inst_d;

  logic                  skid_valid_q,   skid_valid_d;
  logic [IMM_WIDTH-1:0]  skid_imm_q,     skid_imm_d;
  logic [2:0]            skid_type_q,    skid_type_d;
  logic                  skid_illegal_q, skid_illegal_d;
  logic [INST_WIDTH-1:0] skid_inst_q,    skid_inst_d;

  logic in_xfer;

  // in_ready depends only on registered state, so out_ready never reaches it
  assign in_ready = ~skid_valid_q;
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_type_d     = out_type_q;
    out_illegal_d  = out_illegal_q;
    out_inst_d     = out_inst_q;
    skid_valid_d   = skid_valid_q;
    skid_imm_d     = skid_imm_q;
    skid_type_d    = skid_type_q;
    skid_illegal_d = skid_illegal_q;
    skid_inst_d    = skid_inst_q;

    if (flush) begin
      // Data fields are left stale; only the valid bits matter
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot is free this cycle: oldest entry (skid) goes first.
      // in_ready is low whenever the skid is full, so no input can be lost.
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_imm_d     = skid_imm_q;
        out_type_d    = skid_type_q;
        out_illegal_d = skid_illegal_q;
        out_inst_d    = skid_inst_q;
        skid_valid_d  = 1'b0;
      end else if (in_xfer) begin
        out_valid_d   = 1'b1;
        out_imm_d     = dec_imm;
        out_type_d    = dec_type;
        out_illegal_d = dec_illegal;
        out_inst_d    = inst_in;
      end else begin
        out_valid_d   = 1'b0;
      end
    end else if (in_xfer) begin
      // Output stalled: park the new entry in the skid register
      skid_valid_d   = 1'b1;
      skid_imm_d     = dec_imm;
      skid_type_d    = dec_type;
      skid_illegal_d = dec_illegal;
      skid_inst_d    = inst_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_type_q     <= '0;
      out_illegal_q  <= 1'b0;
      out_inst_q     <= '0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_type_q    <= '0;
      skid_illegal_q <= 1'b0;
      skid_inst_q    <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_type_q     <= out_type_d;
      out_illegal_q  <= out_illegal_d;
      out_inst_q     <= out_inst_d;
      skid_valid_q   <= skid_valid_d;
      skid_imm_q     <= skid_imm_d;
      skid_type_q    <= skid_type_d;
      skid_illegal_q <= skid_illegal_d;
      skid_inst_q    <= skid_inst_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign imm_out     = out_imm_q;
  assign type_out    = out_type_q;
  assign illegal_out = out_illegal_q;
  assign inst_out    = out_inst_q;

endmodule
`default_nettype wire
